// File: rtl/operand_loader_if.sv
// Host-side bundle of the operand loader: load request, word stream, BRAM port-2 write
// and the mon_prod start/stop handshake. The master is the host, the slave the loader.
interface operand_loader_if #(
  parameter int ABITS = 8,
  parameter int DBITS = 256,
  parameter int WBITS = 32
);
  logic             load_go;
  logic [ABITS-1:0] base_addr;
  logic [ABITS-1:0] num_lines;
  logic             in_valid;
  logic [WBITS-1:0] in_data;
  logic             in_last;
  logic             in_ready;
  logic [ABITS-1:0] wr_addr2;
  logic [DBITS-1:0] wr_data2;
  logic             wr_en2;
  logic             mp_start;
  logic             mp_stop;
  logic             busy;
  logic             done;

  modport master (
    output load_go, base_addr, num_lines, in_valid, in_data, in_last, mp_stop,
    input  in_ready, wr_addr2, wr_data2, wr_en2, mp_start, busy, done
  );

  modport slave (
    input  load_go, base_addr, num_lines, in_valid, in_data, in_last, mp_stop,
    output in_ready, wr_addr2, wr_data2, wr_en2, mp_start, busy, done
  );
endinterface

// File: rtl/operand_loader.sv
// Packs a WBITS word stream into DBITS lines, writes them through BRAM port 2, then runs
// the mon_prod start/stop handshake. Define OPLOAD_ZPAD_EN to let in_last end a line early.
module operand_loader #(
  parameter int ABITS = 8,
  parameter int DBITS = 256,
  parameter int WBITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  operand_loader_if.slave      bus
);
  localparam int NWORDS = DBITS / WBITS;
  localparam int WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [2:0] {IDLE, FILL, WRITE, LAUNCH, WAIT, DONE} state_t;

  state_t           state;
  logic [ABITS-1:0] base_q;
  logic [ABITS-1:0] num_q;
  logic [ABITS-1:0] line_idx;
  logic [WCW-1:0]   word_cnt;
  logic [DBITS-1:0] pack;
  logic [DBITS-1:0] next_line;
  logic             line_end;

  // NOTE: every variable written in always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_line = pack;
    next_line[word_cnt*WBITS +: WBITS] = bus.in_data;
  end

`ifdef OPLOAD_ZPAD_EN
  assign line_end = (word_cnt == WCW'(NWORDS - 1)) || bus.in_last;
`else
  assign line_end = (word_cnt == WCW'(NWORDS - 1));
  logic unused_last;
  assign unused_last = bus.in_last;
`endif

  // NOTE: state is updated with non-blocking assignments so every register samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      base_q       <= '0;
      num_q        <= '0;
      line_idx     <= '0;
      word_cnt     <= '0;
      pack         <= '0;
      bus.in_ready <= 1'b0;
      bus.wr_addr2 <= '0;
      bus.wr_data2 <= '0;
      bus.wr_en2   <= 1'b0;
      bus.mp_start <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_go) begin
            base_q   <= bus.base_addr;
            num_q    <= bus.num_lines;
            line_idx <= '0;
            word_cnt <= '0;
            pack     <= '0;
            bus.busy <= 1'b1;
            if (bus.num_lines != '0) begin
              state        <= FILL;
              bus.in_ready <= 1'b1;
            end else begin
              state        <= LAUNCH;
              bus.mp_start <= 1'b1;
            end
          end
        end
        FILL: begin
          if (bus.in_valid) begin
            if (line_end) begin
              // Unfilled upper words stay zero because pack is cleared per line.
              state        <= WRITE;
              bus.in_ready <= 1'b0;
              bus.wr_en2   <= 1'b1;
              bus.wr_addr2 <= base_q + line_idx;
              bus.wr_data2 <= next_line;
              pack         <= '0;
              word_cnt     <= '0;
            end else begin
              pack     <= next_line;
              word_cnt <= word_cnt + WCW'(1);
            end
          end
        end
        WRITE: begin
          bus.wr_en2 <= 1'b0;
          line_idx   <= line_idx + ABITS'(1);
          if (line_idx + ABITS'(1) == num_q) begin
            state        <= LAUNCH;
            bus.mp_start <= 1'b1;
          end else begin
            state        <= FILL;
            bus.in_ready <= 1'b1;
          end
        end
        // One guaranteed WAIT cycle gives mon_prod its start edge even if stop is stale.
        LAUNCH: state <= WAIT;
        WAIT: begin
          if (bus.mp_stop) begin
            state        <= DONE;
            bus.mp_start <= 1'b0;
            bus.done     <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: table of load vectors plus hand sequences for
// early line end / full-line wait and reset during FILL.
module tb_operand_loader;
  localparam int ABITS  = 8;
  localparam int DBITS  = 256;
  localparam int WBITS  = 32;
  localparam int NWORDS = DBITS / WBITS;

  typedef struct {
    logic [7:0]       base;
    logic [7:0]       num;
    bit               bp;
    bit               ramp;
    bit               glitch;
    logic [3:0][31:0] w0;
    logic [3:0][7:0]  exp_addr;
  } vec_t;

  typedef struct {
    logic [7:0]   addr;
    logic [255:0] data;
    int           cyc;
  } wr_rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_loader_if #(.ABITS(ABITS), .DBITS(DBITS), .WBITS(WBITS)) bus ();

  operand_loader #(.ABITS(ABITS), .DBITS(DBITS), .WBITS(WBITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  int      go_cyc = 0;
  int      start_cyc = -1;
  int      done_cnt = 0;
  logic    prev_start = 1'b0;
  wr_rec_t wq[$];
  vec_t    vecs[4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wr_en2) wq.push_back('{bus.wr_addr2, bus.wr_data2, cyc});
    if (bus.mp_start && !prev_start) start_cyc = cyc;
    prev_start = bus.mp_start;
    if (bus.done) done_cnt++;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [7:0] b, input logic [7:0] n);
    bus.base_addr = b;
    bus.num_lines = n;
    bus.load_go   = 1'b1;
    tick();
    bus.load_go   = 1'b0;
    go_cyc        = cyc;
  endtask

  task automatic drive_word(input logic [31:0] d, input bit last, input bit bp);
    bit ok;
    if (bp) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    ok = 1'b0;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) check("accept_timeout", 256'(ok), 256'd1);
  endtask

  task automatic stop_sequence(input string name);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = bus.mp_start;
      if (!seen) tick();
    end
    check({name, "_start_seen"}, 256'(seen), 256'd1);
    repeat (20) tick();
    @(negedge clk);
    check({name, "_start_held"}, 256'(bus.mp_start), 256'd1);
    tick();
    bus.mp_stop = 1'b1;
    tick();
    bus.mp_stop = 1'b0;
    @(negedge clk);
    check({name, "_done_pulse"}, 256'(bus.done), 256'd1);
    check({name, "_start_low"}, 256'(bus.mp_start), 256'd0);
    tick();
    @(negedge clk);
    check({name, "_done_end"}, 256'(bus.done), 256'd0);
    check({name, "_busy_low"}, 256'(bus.busy), 256'd0);
    check({name, "_done_count"}, 256'(done_cnt), 256'd1);
    tick();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [255:0] exp_line;
    string        nm;
    nm = $sformatf("vec%0d", idx);
    wq.delete();
    done_cnt  = 0;
    start_cyc = -1;
    start_load(v.base, v.num);
    for (int i = 0; i < int'(v.num); i++) begin
      for (int k = 0; k < NWORDS; k++) begin
        logic [31:0] w;
        w = v.ramp ? v.w0[i] + 32'(k) : ((k == 0) ? v.w0[i] : 32'd0);
        drive_word(w, 1'b0, v.bp);
      end
      if (v.glitch && i == 0) begin
        bus.base_addr = 8'h10;
        bus.num_lines = 8'h01;
        bus.load_go   = 1'b1;
        tick();
        bus.load_go   = 1'b0;
      end
    end
    stop_sequence(nm);
    check({nm, "_num_writes"}, 256'(wq.size()), 256'(v.num));
    for (int i = 0; i < int'(v.num) && i < wq.size(); i++) begin
      exp_line = '0;
      for (int k = 0; k < NWORDS; k++)
        exp_line[k*32 +: 32] = v.ramp ? v.w0[i] + 32'(k) : ((k == 0) ? v.w0[i] : 32'd0);
      check($sformatf("%s_addr%0d", nm, i), 256'(wq[i].addr), 256'(v.exp_addr[i]));
      check($sformatf("%s_data%0d", nm, i), wq[i].data, exp_line);
    end
    if (v.num == 8'd0)
      check({nm, "_start_lat"}, 256'(start_cyc), 256'(go_cyc));
    else if (wq.size() > 0)
      check({nm, "_start_lat"}, 256'(start_cyc), 256'(wq[wq.size()-1].cyc + 1));
  endtask

  initial begin
    vecs[0] = '{base: 8'h00, num: 8'd4, bp: 1'b0, ramp: 1'b0, glitch: 1'b0,
                w0: {32'd0, 32'd535, 32'd0, 32'd435},
                exp_addr: {8'h03, 8'h02, 8'h01, 8'h00}};
    vecs[1] = '{base: 8'h00, num: 8'd4, bp: 1'b1, ramp: 1'b0, glitch: 1'b0,
                w0: {32'd0, 32'd535, 32'd0, 32'd435},
                exp_addr: {8'h03, 8'h02, 8'h01, 8'h00}};
    vecs[2] = '{base: 8'hFE, num: 8'd3, bp: 1'b0, ramp: 1'b1, glitch: 1'b1,
                w0: {32'd0, 32'h3000, 32'h2000, 32'h1000},
                exp_addr: {8'h00, 8'h00, 8'hFF, 8'hFE}};
    vecs[3] = '{base: 8'h20, num: 8'd0, bp: 1'b0, ramp: 1'b0, glitch: 1'b0,
                w0: '0, exp_addr: '0};

    bus.load_go   = 1'b0;
    bus.base_addr = '0;
    bus.num_lines = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.mp_stop   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("rst_in_ready", 256'(bus.in_ready), 256'd0);
    check("rst_wr_en2", 256'(bus.wr_en2), 256'd0);
    check("rst_mp_start", 256'(bus.mp_start), 256'd0);
    check("rst_busy", 256'(bus.busy), 256'd0);
    check("rst_done", 256'(bus.done), 256'd0);
    check("rst_wr_addr2", 256'(bus.wr_addr2), 256'd0);
    check("rst_wr_data2", bus.wr_data2, 256'd0);
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Short line: three words with in_last on the third.
    wq.delete();
    done_cnt = 0;
    start_load(8'h05, 8'h01);
    drive_word(32'd1, 1'b0, 1'b0);
    drive_word(32'd2, 1'b0, 1'b0);
    drive_word(32'd3, 1'b1, 1'b0);
`ifdef OPLOAD_ZPAD_EN
    stop_sequence("zpad");
    check("zpad_num_writes", 256'(wq.size()), 256'd1);
    if (wq.size() > 0) begin
      check("zpad_addr", 256'(wq[0].addr), 256'h05);
      check("zpad_data", wq[0].data, {160'd0, 32'd3, 32'd2, 32'd1});
    end
`else
    repeat (4) tick();
    @(negedge clk);
    check("nozpad_no_early_write", 256'(wq.size()), 256'd0);
    check("nozpad_still_ready", 256'(bus.in_ready), 256'd1);
    tick();
    for (int k = 4; k <= NWORDS; k++) drive_word(32'(k), 1'b0, 1'b0);
    stop_sequence("nozpad");
    check("nozpad_num_writes", 256'(wq.size()), 256'd1);
    if (wq.size() > 0) begin
      check("nozpad_addr", 256'(wq[0].addr), 256'h05);
      check("nozpad_data", wq[0].data,
            {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
    end
`endif

    // Reset asserted in the middle of FILL aborts the load with no write.
    wq.delete();
    start_load(8'h40, 8'h02);
    drive_word(32'hAAAA, 1'b0, 1'b0);
    drive_word(32'hBBBB, 1'b0, 1'b0);
    drive_word(32'hCCCC, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    check("rstmid_no_write", 256'(wq.size()), 256'd0);
    check("rstmid_busy", 256'(bus.busy), 256'd0);
    check("rstmid_in_ready", 256'(bus.in_ready), 256'd0);
    check("rstmid_mp_start", 256'(bus.mp_start), 256'd0);
    check("rstmid_wr_data2", bus.wr_data2, 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
